// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the five-stage MIPS core.
//
// Generates the PC / IF/ID / ID/EX write and flush controls from the EX-side
// outputs of the ID/EX register (load, destination, branch outcome) and the
// operands of the instruction sitting in ID. Also arbitrates external
// interrupt entry and keeps saturating stall / flush profiling counters.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   ID_RegisterRs/Rt   source fields of the ID instruction
//   ID_UsesRt          ID instruction reads rt
//   ID_Valid           ID holds a real instruction
//   ID_isJ             nonzero when a jump resolves in ID
//   EX_MemRd           EX instruction is a load
//   EX_RegisterRd      resolved destination of the EX instruction
//   EX_isBranch        EX instruction is a conditional branch
//   EX_BranchTaken     branch condition (valid with EX_isBranch)
//   Irq, IrqEnable     level interrupt request and global enable
//   CntClear           synchronous clear of both counters
//   PC_Write           PC may update
//   IF_ID_Write        IF/ID may load
//   IF_ID_Flush        IF/ID loads a bubble
//   ID_EX_Flush        ID/EX loads a bubble
//   PC_SrcSel          0 sequential, 1 branch target, 2 interrupt vector
//   Irq_Take           one-cycle interrupt acceptance strobe
//   StallCount         saturating count of load-use stall cycles
//   FlushCount         saturating count of cycles with any flush
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_RegisterRs,
  input  logic [4:0]       ID_RegisterRt,
  input  logic             ID_UsesRt,
  input  logic             ID_Valid,
  input  logic [1:0]       ID_isJ,
  input  logic             EX_MemRd,
  input  logic [4:0]       EX_RegisterRd,
  input  logic             EX_isBranch,
  input  logic             EX_BranchTaken,
  input  logic             Irq,
  input  logic             IrqEnable,
  input  logic             CntClear,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic [1:0]       PC_SrcSel,
  output logic             Irq_Take,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    IRQ_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic bt_s;      // taken branch in EX
  logic lu_s;      // load-use dependency between EX and ID
  logic jp_s;      // jump resolving in ID
  logic take_s;    // interrupt accepted this cycle
  logic stall_s;   // load-use stall actually applied
  logic flush_s;   // any flush asserted this cycle

  // Hazard terms; $zero as a load destination is never a real dependency.
  always_comb begin
    bt_s    = EX_isBranch & EX_BranchTaken;
    lu_s    = EX_MemRd & (EX_RegisterRd != 5'd0) &
              ((EX_RegisterRd == ID_RegisterRs) |
               (ID_UsesRt & (EX_RegisterRd == ID_RegisterRt)));
    jp_s    = (ID_isJ != 2'd0);
    stall_s = lu_s & ~bt_s & ~reset;
    // Only RUN may accept: BUBBLE has a bubble in EX, IRQ_HOLD waits for Irq low.
    take_s  = (state_r == RUN) & Irq & IrqEnable & ID_Valid & ~bt_s & ~lu_s & ~reset;
  end

  // Prioritised control outputs: branch > load-use > interrupt > jump > idle.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    PC_SrcSel   = 2'd0;
    Irq_Take    = 1'b0;
    if (reset) begin
      PC_Write = 1'b1;
    end else if (bt_s) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      PC_SrcSel   = 2'd1;
    end else if (lu_s) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (take_s) begin
      Irq_Take    = 1'b1;
      PC_SrcSel   = 2'd2;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (jp_s) begin
      // Jump target selection happens outside; only the wrong-path fetch is killed.
      IF_ID_Flush = 1'b1;
    end else begin
      PC_SrcSel = 2'd0;
    end
  end

  always_comb begin
    flush_s = IF_ID_Flush | ID_EX_Flush;
  end

  // Sequencing state: post-stall bubble and interrupt-hold tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (stall_s) begin
            state_r <= BUBBLE;
          end else if (take_s) begin
            state_r <= IRQ_HOLD;
          end else begin
            state_r <= RUN;
          end
        end
        BUBBLE: begin
          state_r <= RUN;
        end
        IRQ_HOLD: begin
          if (!Irq) begin
            state_r <= RUN;
          end else begin
            state_r <= IRQ_HOLD;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  // Saturating profiling counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (CntClear) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign StallCount = stall_cnt_r;
  assign FlushCount = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Each step drives inputs just after a rising
// edge, pushes the required control vector to a scoreboard queue, and pops and
// compares it at the falling edge. Counter expectations come from a small
// saturating model updated from the required control vector.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  ID_RegisterRs;
  logic [4:0]  ID_RegisterRt;
  logic        ID_UsesRt;
  logic        ID_Valid;
  logic [1:0]  ID_isJ;
  logic        EX_MemRd;
  logic [4:0]  EX_RegisterRd;
  logic        EX_isBranch;
  logic        EX_BranchTaken;
  logic        Irq;
  logic        IrqEnable;
  logic        CntClear;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic [1:0]  PC_SrcSel;
  logic        Irq_Take;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
    .ID_UsesRt(ID_UsesRt), .ID_Valid(ID_Valid), .ID_isJ(ID_isJ),
    .EX_MemRd(EX_MemRd), .EX_RegisterRd(EX_RegisterRd),
    .EX_isBranch(EX_isBranch), .EX_BranchTaken(EX_BranchTaken),
    .Irq(Irq), .IrqEnable(IrqEnable), .CntClear(CntClear),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .PC_SrcSel(PC_SrcSel), .Irq_Take(Irq_Take),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_SrcSel[1:0], Irq_Take}
  localparam logic [6:0] E_IDLE  = 7'b1100_000;
  localparam logic [6:0] E_STALL = 7'b0001_000;
  localparam logic [6:0] E_BR    = 7'b1111_010;
  localparam logic [6:0] E_JMP   = 7'b1110_000;
  localparam logic [6:0] E_IRQ   = 7'b1111_101;

  int compared = 0;
  int mismatched = 0;
  logic [6:0]  sb_q[$];
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already driven; compare controls and counters, advance model.
  task automatic cycle(input logic [6:0] exp_ctl, input string tag);
    logic [6:0] obs;
    logic [6:0] e;
    sb_q.push_back(exp_ctl);
    @(negedge clk);
    obs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_SrcSel, Irq_Take};
    e = sb_q.pop_front();
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, e);
    end
    chk16({tag, "_stall"}, StallCount, exp_stall);
    chk16({tag, "_flush"}, FlushCount, exp_flush);
    if (CntClear) begin
      exp_stall = 16'd0;
      exp_flush = 16'd0;
    end else begin
      if (!e[6]) exp_stall = sat_inc(exp_stall);
      if (e[4] | e[3]) exp_flush = sat_inc(exp_flush);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ID_RegisterRs = 5'd1; ID_RegisterRt = 5'd2; ID_UsesRt = 1'b0;
    ID_Valid = 1'b1; ID_isJ = 2'd0; EX_MemRd = 1'b0; EX_RegisterRd = 5'd0;
    EX_isBranch = 1'b0; EX_BranchTaken = 1'b0; Irq = 1'b0; IrqEnable = 1'b1;
    CntClear = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] r);
    EX_MemRd = 1'b1; EX_RegisterRd = r; ID_RegisterRs = r;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    Irq = 1'b1;  // request pending during reset must not be taken
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    assert ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_SrcSel, Irq_Take} === E_IDLE)
      else begin
        mismatched++;
        $error("FAIL reset_ctl observed=%b expected=%b",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_SrcSel, Irq_Take}, E_IDLE);
      end
    chk16("reset_stall", StallCount, 16'd0);
    chk16("reset_flush", FlushCount, 16'd0);
    Irq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    cycle(E_IDLE, "idle");
    load_use(5'd8);                 cycle(E_STALL, "lu_rs");
    quiet(); Irq = 1'b1;            cycle(E_IDLE, "irq_in_bubble");
    cycle(E_IRQ, "irq_take1");
    for (int i = 0; i < 5; i++) cycle(E_IDLE, "irq_hold");
    Irq = 1'b0;                     cycle(E_IDLE, "irq_low");
    Irq = 1'b1;                     cycle(E_IRQ, "irq_take2");
    Irq = 1'b0;                     cycle(E_IDLE, "irq_release");

    EX_MemRd = 1'b1; EX_RegisterRd = 5'd8; ID_RegisterRs = 5'd3;
    ID_RegisterRt = 5'd8; ID_UsesRt = 1'b0;
                                    cycle(E_IDLE, "rt_unused");
    ID_UsesRt = 1'b1;               cycle(E_STALL, "lu_rt");
    quiet(); load_use(5'd9);        cycle(E_STALL, "lu_back2back");
    quiet(); load_use(5'd0);        cycle(E_IDLE, "rd_zero");
    quiet(); load_use(5'd5); Irq = 1'b1;
                                    cycle(E_STALL, "irq_with_lu");
    quiet(); Irq = 1'b1;            cycle(E_IDLE, "irq_deferred");
    cycle(E_IRQ, "irq_after_defer");
    Irq = 1'b0;                     cycle(E_IDLE, "irq_drop");

    quiet(); load_use(5'd8); EX_isBranch = 1'b1; EX_BranchTaken = 1'b1;
                                    cycle(E_BR, "bt_and_lu");
    quiet(); EX_isBranch = 1'b1;    cycle(E_IDLE, "bnt");
    quiet(); ID_isJ = 2'd2;         cycle(E_JMP, "jump");
    Irq = 1'b1;                     cycle(E_IRQ, "irq_over_jump");
    quiet();                        cycle(E_IDLE, "post_jump");
    quiet(); ID_Valid = 1'b0; Irq = 1'b1;
                                    cycle(E_IDLE, "irq_invalid_id");
    quiet(); Irq = 1'b1; EX_isBranch = 1'b1; EX_BranchTaken = 1'b1;
                                    cycle(E_BR, "bt_with_irq");
    quiet();                        cycle(E_IDLE, "pre_sat");

    quiet(); load_use(5'd8);
    for (int i = 0; i < 65536; i++) cycle(E_STALL, "sat");
    chk16("sat_value", StallCount, 16'hFFFF);
    CntClear = 1'b1;                cycle(E_STALL, "clear_with_stall");
    quiet();                        cycle(E_IDLE, "after_clear");

    // Enter IRQ_HOLD, then reset asynchronously between edges.
    quiet(); Irq = 1'b1;            cycle(E_IRQ, "irq_take3");
    #2 reset = 1'b1;
    #1;
    chk16("async_rst_stall", StallCount, 16'd0);
    chk16("async_rst_flush", FlushCount, 16'd0);
    compared++;
    assert (Irq_Take === 1'b0) else begin
      mismatched++;
      $error("FAIL async_rst_take observed=%b expected=%b", Irq_Take, 1'b0);
    end
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(E_IRQ, "irq_after_reset");
    Irq = 1'b0;                     cycle(E_IDLE, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It drives the flush/stall controls consumed by the IF/ID and ID/EX pipeline registers, including the `ID_EX_Flush` input of the ID/EX register. It closes the loop from the EX-side outputs of ID/EX (MemRd, destination register, branch outcome) back to IF and ID. It also arbitrates external-interrupt entry and keeps saturating stall and flush counters for profiling.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `ID_RegisterRs` input 5: rs field of the instruction in ID.
- `ID_RegisterRt` input 5: rt field of the instruction in ID.
- `ID_UsesRt` input 1: the ID instruction reads rt as a source.
- `ID_Valid` input 1: ID holds a real instruction, not a bubble.
- `ID_isJ` input 2: nonzero means a jump resolves in ID this cycle.
- `EX_MemRd` input 1: the EX instruction is a load.
- `EX_RegisterRd` input 5: resolved destination of the EX instruction.
- `EX_isBranch` input 1: the EX instruction is a conditional branch.
- `EX_BranchTaken` input 1: branch condition true, valid when `EX_isBranch`.
- `Irq` input 1: level-sensitive external interrupt request.
- `IrqEnable` input 1: interrupts permitted.
- `CntClear` input 1: synchronous clear of both counters.
- `PC_Write` output 1: PC may update.
- `IF_ID_Write` output 1: IF/ID may load.
- `IF_ID_Flush` output 1: IF/ID loads a bubble.
- `ID_EX_Flush` output 1: ID/EX loads a bubble.
- `PC_SrcSel` output 2: 0 sequential/normal, 1 branch target, 2 interrupt vector.
- `Irq_Take` output 1: one-cycle strobe; the ID instruction's PC is saved as the return address.
- `StallCount` output CNT_W: number of load-use stall cycles.
- `FlushCount` output CNT_W: number of cycles with any flush asserted.

## Operation
- Terms, all computed combinationally each cycle:
  - `bt` = `EX_isBranch & EX_BranchTaken`.
  - `lu` = `EX_MemRd & EX_RegisterRd!=0 & (EX_RegisterRd==ID_RegisterRs | (ID_UsesRt & EX_RegisterRd==ID_RegisterRt))`.
  - `jp` = `ID_isJ!=0`.
- Priority: `bt` > `lu` > interrupt > `jp`.
- On `bt`:
  - `IF_ID_Flush=1`, `ID_EX_Flush=1`, `PC_SrcSel=1`, `PC_Write=1`.
  - The load-use check is ignored.
- On `lu` without `bt`:
  - `PC_Write=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`.
- On `jp` only:
  - `IF_ID_Flush=1`. The jump target mux is outside this block, so `PC_SrcSel=0`.
- Interrupt acceptance:
  - Condition: state RUN, `Irq & IrqEnable & ID_Valid`, and no `bt` or `lu`.
  - Outputs: `Irq_Take=1`, `PC_SrcSel=2`, `IF_ID_Flush=1`, `ID_EX_Flush=1`.
  - Acceptance overrides `jp`.
- Idle (no event): `PC_Write=1`, `IF_ID_Write=1`, both flushes 0, `PC_SrcSel=0`.
- FSM states:
  - RUN: normal.
  - BUBBLE: entered the cycle after a `lu` stall. It lasts one cycle and blocks interrupt acceptance, because EX holds a bubble.
  - IRQ_HOLD: entered after `Irq_Take`. It stays until `Irq` is sampled low, then returns to RUN. Hazards keep working in every state; only interrupt acceptance is blocked.
- FSM transitions:
  - RUN → BUBBLE on `lu & ~bt`.
  - RUN → IRQ_HOLD on `Irq_Take`.
  - BUBBLE → RUN unconditionally.
  - IRQ_HOLD → RUN when `~Irq`.
- Counters saturate at all-ones.
  - `StallCount` increments on each cycle with `lu & ~bt`.
  - `FlushCount` increments on each cycle with `IF_ID_Flush | ID_EX_Flush`.
  - `CntClear` has priority over increment.

## Timing
- Control outputs are combinational from inputs and the state register, with zero latency. They are consumed at the same edge by the pipeline registers.
- State and counters update on the rising edge of `clk`.
- Reset behaviour:
  - Asynchronous `reset=1` forces state RUN and both counters to 0 immediately.
  - While reset is held, outputs are `PC_Write=1`, `IF_ID_Write=1`, `IF_ID_Flush=0`, `ID_EX_Flush=0`, `PC_SrcSel=0`, `Irq_Take=0`.
  - Reset mid-stall or in IRQ_HOLD abandons that state with no residual effect.
- Load-use stall length:
  - Exactly one cycle. The next cycle EX holds the bubble, so `lu`=0 naturally.
  - Back-to-back loads each cost one cycle.
- `Irq_Take` is never high on two consecutive cycles. If `Irq` stays high, it is not re-asserted until `Irq` has been low for at least one sampled cycle.
- `EX_RegisterRd==0` never stalls, because $zero is not a real destination.

## Test plan
- Load-use on rs:
  - Stimulus: `EX_MemRd=1`, `EX_RegisterRd=8`, `ID_RegisterRs=8`.
  - Required: `PC_Write=0`, `IF_ID_Write=0`, `ID_EX_Flush=1` for one cycle, then state BUBBLE and `StallCount=1`.
  - Variants: rt=8 with `ID_UsesRt=0` → no stall; rd=0 → no stall.
- Branch taken coincident with load-use:
  - Stimulus: `bt` and `lu` both true.
  - Required: `PC_SrcSel=1`, both flushes 1, `PC_Write=1`, `StallCount` unchanged, `FlushCount` +1.
- Jump in ID:
  - Stimulus: `ID_isJ=2`, nothing else active.
  - Required: `IF_ID_Flush=1`, `ID_EX_Flush=0`, `PC_SrcSel=0`.
- Interrupt:
  - Stimulus: `Irq=1`, `IrqEnable=1`, `ID_Valid=1` in RUN.
  - Required: `Irq_Take` one cycle with `PC_SrcSel=2`. Holding `Irq` high 5 more cycles gives no further `Irq_Take`. Dropping `Irq` for one cycle and raising it again gives a second `Irq_Take`.
  - Variants: `Irq` during BUBBLE or with `lu` active → deferred.
- Counter saturation and clear:
  - Stimulus: force 65536 stall cycles.
  - Required: `StallCount=16'hFFFF`.
  - Then `CntClear` with a simultaneous stall → 0.
- Reset mid-IRQ_HOLD:
  - Stimulus: assert `reset` asynchronously between edges.
  - Required: counters read 0 before the next edge, state RUN, and an `Irq` still high is accepted on the first cycle after reset release.
